// File: rtl/pipe_incr.sv
// Pipelined step incrementer with wrap/saturate modes and overflow flag.
// Valid/ready stream in and out, full backpressure, registered occupancy.
module pipe_incr #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNTW   = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_step,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNTW-1:0]  occupancy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] o;
  logic [WIDTH-1:0]  d [STAGES];
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  res;
  logic              acc;
  logic              in_fire;
  logic              out_fire;
  logic [CNTW-1:0]   cnt;

  // A stage may load when it is empty or everything downstream moves.
  always_comb begin
    adv = '0;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = ~v[k] | acc;
      adv[k] = acc;
    end
  end

  always_comb begin
    sum = {1'b0, in_data} + {1'b0, in_step};
    res = (in_sat && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign out_ovf   = o[STAGES-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      o <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        d[0] <= res;
        o[0] <= sum[WIDTH];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
          o[k] <= o[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_incr.sv
// Self-checking bench for pipe_incr: directed vectors plus randomized
// stream against a queue-based reference model.
module tb_pipe_incr;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] in_step;
  logic         in_sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic [1:0]   occupancy;

  pipe_incr #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_step(in_step),
    .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         o;
  } word_t;

  word_t q[$];
  word_t lg[$];
  int    passed = 0;
  int    total = 0;
  int    cyc = 0;
  int    first_in, first_out, last_out;
  int    nin, nout;
  int    noready;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic word_t model(input int a, input int s,
                                  input bit sat);
    word_t r;
    int    sm;
    sm  = a + s;
    r.o = (sm > 255);
    r.d = (sat && r.o) ? 8'hFF : 8'(sm % 256);
    return r;
  endfunction

  task automatic clr_stats();
    first_in  = -1;
    first_out = -1;
    last_out  = -1;
    nin       = 0;
    nout      = 0;
    noready   = 0;
    lg.delete();
  endtask

  task automatic step(input logic iv, input logic [W-1:0] id,
                      input logic [W-1:0] is, input logic isat,
                      input logic ordy);
    bit    inf, outf;
    word_t e;
    in_valid  = iv;
    in_data   = id;
    in_step   = is;
    in_sat    = isat;
    out_ready = ordy;
    #3;
    inf  = in_valid & in_ready;
    outf = out_valid & out_ready;
    if (iv && !in_ready) noready++;
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() == 0) chk("no_stale", 32'(out_valid), 0);
    if (outf && q.size() != 0) begin
      e = q.pop_front();
      chk("out_data", 32'(out_data), 32'(e.d));
      chk("out_ovf", 32'(out_ovf), 32'(e.o));
      lg.push_back('{d: out_data, o: out_ovf});
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      nout++;
    end
    if (inf) begin
      q.push_back(model(int'(id), int'(is), isat));
      if (first_in < 0) first_in = cyc;
      nin++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    logic [W-1:0] held;
    int           n;
    rst = 0;
    in_valid = 0; in_data = 0; in_step = 0;
    in_sat = 0; out_ready = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_occupancy", 32'(occupancy), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;

    // legacy equivalence: step 1, wrap
    clr_stats();
    step(1, 8'h00, 8'h01, 0, 1);
    step(1, 8'h13, 8'h01, 0, 1);
    step(1, 8'h27, 8'h01, 0, 1);
    drain(20);
    chk("leg_n", 32'(lg.size()), 3);
    if (lg.size() == 3) begin
      chk("leg0", 32'(lg[0]), {8'h01, 1'b0});
      chk("leg1", 32'(lg[1]), {8'h14, 1'b0});
      chk("leg2", 32'(lg[2]), {8'h28, 1'b0});
    end

    // wrap vs saturate, step 0
    clr_stats();
    step(1, 8'hFF, 8'h02, 0, 1);
    step(1, 8'hFF, 8'h02, 1, 1);
    step(1, 8'hF0, 8'h0F, 1, 1);
    step(1, 8'h5A, 8'h00, 1, 1);
    drain(20);
    chk("ws_n", 32'(lg.size()), 4);
    if (lg.size() == 4) begin
      chk("wrap_ff", 32'(lg[0]), {8'h01, 1'b1});
      chk("sat_ff", 32'(lg[1]), {8'hFF, 1'b1});
      chk("sat_f0", 32'(lg[2]), {8'hFF, 1'b0});
      chk("step0", 32'(lg[3]), {8'h5A, 1'b0});
    end

    // latency and throughput
    clr_stats();
    for (int i = 0; i < 10; i++) step(1, 8'(i), 8'h05, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("lat", 32'(first_out - first_in), S);
    chk("tput_span", 32'(last_out - first_out), 9);
    chk("tput_n", 32'(nout), 10);
    chk("tput_stall", 32'(noready), 0);
    if (lg.size() == 10) begin
      chk("tput_first", 32'(lg[0].d), 5);
      chk("tput_last", 32'(lg[9].d), 14);
    end

    // backpressure
    clr_stats();
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'h40 + i), 8'h03, 0, 0);
      if (i == 3) held = out_data;
    end
    chk("bp_accepts", 32'(nin), S);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_occ", 32'(occupancy), S);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_stable", 32'(out_data), 32'(held));
    chk("bp_head", 32'(out_data), 8'h43);
    drain(20);
    chk("bp_out_n", 32'(nout), S);
    chk("bp_occ0", 32'(occupancy), 0);

    // random stall stream
    clr_stats();
    n = 0;
    while (nin < 1000 && n < 20000) begin
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom),
           1'($urandom), ($urandom % 3) != 0);
      n++;
    end
    chk("rnd_sent", 32'(nin), 1000);
    drain(50);
    chk("rnd_recv", 32'(nout), 1000);

    // reset mid-stream with two words in flight
    clr_stats();
    step(1, 8'h21, 8'h01, 0, 0);
    step(1, 8'h22, 8'h01, 0, 0);
    in_valid = 0;
    #2;
    rst = 0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_out_data", 32'(out_data), 0);
    chk("mr_occ", 32'(occupancy), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1;
    @(posedge clk); #1;
    clr_stats();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("mr_no_stale", 32'(nout), 0);
    step(1, 8'h10, 8'h01, 0, 1);
    drain(20);
    chk("mr_n", 32'(lg.size()), 1);
    if (lg.size() == 1) chk("mr_word", 32'(lg[0]), {8'h11, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
